// File: rtl/pic_int_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_sequencer_if
// Description : Request/mask inputs, EOI command, mode configuration and
//               CPU-side interrupt/vector outputs of the PIC interrupt
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pic_int_sequencer_if;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta;
    logic       eoi;
    logic       eoi_spec;
    logic [2:0] eoi_lvl;
    logic       rot_eoi;
    logic       aeoi;
    logic       ar;
    logic       fn;
    logic       int_o;
    logic [7:0] isr;
    logic [7:0] irr_clr;
    logic       vec_valid;
    logic [7:0] vec;
    logic [2:0] pri_base;

    // Sequencer side
    modport slave (
        input  irr, imr, inta, eoi, eoi_spec, eoi_lvl, rot_eoi, aeoi, ar, fn,
        output int_o, isr, irr_clr, vec_valid, vec, pri_base
    );

    // Register block / CPU side
    modport master (
        output irr, imr, inta, eoi, eoi_spec, eoi_lvl, rot_eoi, aeoi, ar, fn,
        input  int_o, isr, irr_clr, vec_valid, vec, pri_base
    );
endinterface
`default_nettype wire

// File: rtl/pic_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pic_int_sequencer
// Description : Interrupt-cycle controller for an 8-level PIC. Holds the ISR
//               and rotating priority base, raises INT, runs the two-pulse
//               INTA handshake and services specific / non-specific / auto
//               EOI with optional rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module pic_int_sequencer #(
    parameter logic [4:0] VEC_BASE = 5'b00001,
    parameter logic [2:0] SPUR_LVL = 3'd7
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    pic_int_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_ACK2 = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_int,   w_int_nxt;
    logic [7:0] r_isr,   w_isr_nxt;
    logic [7:0] r_irr_clr, w_irr_clr_nxt;
    logic       r_vec_valid, w_vec_valid_nxt;
    logic [7:0] r_vec,   w_vec_nxt;
    logic [2:0] r_pri_base, w_pri_nxt;
    logic [2:0] r_lvl,   w_lvl_nxt;
    logic       r_spur,  w_spur_nxt;

    logic [7:0] w_set, w_aeoi_clr, w_eoi_clr;
    logic       w_aeoi_rot, w_eoi_rot;
    logic [2:0] w_eoi_lvl;
    logic [3:0] w_win, w_isr_top, w_eoi_top;
    logic       w_blocked, w_req;

    // Highest-priority set bit of 'bits' relative to 'base': {found, level}.
    // Scanned from lowest to highest priority so the last hit wins.
    function automatic logic [3:0] f_top(input logic [7:0] bits, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int r = 7; r >= 0; r--) begin
            lvl = base + 3'd1 + 3'(r);
            if (bits[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    // Rank of a level: 0 is the highest priority (just above the base).
    function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] base);
        return lvl - base - 3'd1;
    endfunction

    // Arbitration: winning request and whether an in-service level blocks it.
    always_comb begin
        w_win     = f_top(bus.irr & ~bus.imr, r_pri_base);
        w_isr_top = f_top(bus.fn ? r_isr : (r_isr & ~bus.imr), r_pri_base);
        w_eoi_top = f_top(r_isr, r_pri_base);
        w_blocked = w_isr_top[3] &&
                    (f_rank(w_isr_top[2:0], r_pri_base) <= f_rank(w_win[2:0], r_pri_base));
        w_req     = w_win[3] && !w_blocked;
    end

    // Handshake FSM next state and per-cycle strobes.
    always_comb begin
        w_state_nxt     = r_state;
        w_int_nxt       = r_int;
        w_set           = 8'd0;
        w_irr_clr_nxt   = 8'd0;
        w_lvl_nxt       = r_lvl;
        w_spur_nxt      = r_spur;
        w_vec_valid_nxt = 1'b0;
        w_vec_nxt       = r_vec;
        w_aeoi_clr      = 8'd0;
        w_aeoi_rot      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_int_nxt = 1'b0;
                if (w_req) begin
                    w_int_nxt   = 1'b1;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (bus.inta) begin
                    w_int_nxt   = 1'b0;
                    w_state_nxt = S_ACK2;
                    if (w_win[3]) begin
                        w_lvl_nxt     = w_win[2:0];
                        w_spur_nxt    = 1'b0;
                        w_set         = 8'b1 << w_win[2:0];
                        w_irr_clr_nxt = 8'b1 << w_win[2:0];
                    end else begin
                        w_lvl_nxt  = SPUR_LVL;
                        w_spur_nxt = 1'b1;
                    end
                end
            end
            S_ACK2: begin
                if (bus.inta) begin
                    w_vec_valid_nxt = 1'b1;
                    w_vec_nxt       = {VEC_BASE, r_lvl};
                    w_state_nxt     = S_IDLE;
                    if (bus.aeoi && !r_spur) begin
                        w_aeoi_clr = 8'b1 << r_lvl;
                        w_aeoi_rot = bus.ar;
                    end
                end
            end
            default: begin
                w_int_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // EOI command decode and combined ISR / priority-base update.
    always_comb begin
        w_eoi_clr = 8'd0;
        w_eoi_rot = 1'b0;
        w_eoi_lvl = 3'd0;
        if (bus.eoi) begin
            if (bus.eoi_spec) begin
                if (r_isr[bus.eoi_lvl]) begin
                    w_eoi_clr = 8'b1 << bus.eoi_lvl;
                    w_eoi_rot = bus.rot_eoi;
                    w_eoi_lvl = bus.eoi_lvl;
                end
            end else if (w_eoi_top[3]) begin
                w_eoi_clr = 8'b1 << w_eoi_top[2:0];
                w_eoi_rot = bus.rot_eoi;
                w_eoi_lvl = w_eoi_top[2:0];
            end
        end
        // A newly granted level must survive a coincident clear of the same bit.
        w_isr_nxt = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_set;
        w_pri_nxt = w_aeoi_rot ? r_lvl : (w_eoi_rot ? w_eoi_lvl : r_pri_base);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int       <= 1'b0;
            r_isr       <= 8'd0;
            r_irr_clr   <= 8'd0;
            r_vec_valid <= 1'b0;
            r_vec       <= 8'd0;
            r_pri_base  <= 3'd7;
            r_lvl       <= 3'd0;
            r_spur      <= 1'b0;
        end else begin
            r_int       <= w_int_nxt;
            r_isr       <= w_isr_nxt;
            r_irr_clr   <= w_irr_clr_nxt;
            r_vec_valid <= w_vec_valid_nxt;
            r_vec       <= w_vec_nxt;
            r_pri_base  <= w_pri_nxt;
            r_lvl       <= w_lvl_nxt;
            r_spur      <= w_spur_nxt;
        end
    end

    assign bus.int_o     = r_int;
    assign bus.isr       = r_isr;
    assign bus.irr_clr   = r_irr_clr;
    assign bus.vec_valid = r_vec_valid;
    assign bus.vec       = r_vec;
    assign bus.pri_base  = r_pri_base;

endmodule
`default_nettype wire

// File: doc/pic_int_sequencer.md
Name: pic_int_sequencer

Overview:
- Interrupt-cycle controller for the 8-level PIC.
- Holds the In-Service Register (ISR) and the rotating priority base.
- Raises INT when an unmasked request outranks current service, and runs the two-pulse INTA handshake: pulse 1 latches the winner and sets ISR; pulse 2 presents the vector.
- Handles specific, non-specific and automatic EOI, with optional rotation. Sits between the IRR/IMR registers and the CPU bus interface.

Parameters:
- VEC_BASE, 5'b00001, upper five bits of the vector byte; vector = {VEC_BASE, level[2:0]}.
- SPUR_LVL, 3'd7, level reported when no eligible request remains at INTA pulse 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irr  in  8  latched interrupt requests, bit n = IRn.
- imr  in  8  mask; 1 = masked.
- inta  in  1  one-cycle strobe per CPU INTA pulse.
- eoi  in  1  one-cycle EOI command strobe.
- eoi_spec  in  1  qualifies eoi: 1 = specific, 0 = non-specific.
- eoi_lvl  in  3  level for specific EOI.
- rot_eoi  in  1  qualifies eoi: rotate priority on this EOI.
- aeoi  in  1  auto-EOI mode (static configuration).
- ar  in  1  rotate on auto-EOI (static configuration).
- fn  in  1  fully-nested mode; 0 = special mask (masked ISR levels do not block).
- int_o  out  1  interrupt request to CPU.
- isr  out  8  in-service register.
- irr_clr  out  8  one-cycle pulse clearing the serviced IRR bit.
- vec_valid  out  1  one-cycle pulse: vector valid.
- vec  out  8  vector byte; held until the next vec_valid.
- pri_base  out  3  current lowest-priority level.

Behaviour:
- Reset (async, rst_n=0): isr=0, int_o=0, irr_clr=0, vec_valid=0, vec=0, pri_base=7 (IR0 highest), FSM=IDLE. Reset mid-handshake abandons the cycle with no ISR change.
- Priority rank: rank(n) = (n - pri_base - 1) mod 8; rank 0 is highest.
- Eligible request set: irr & ~imr. The winner is the eligible request with the lowest rank.
- Blocking: winner is blocked if some isr bit has rank <= its rank. When fn=0, only isr & ~imr bits count for blocking.
- FSM IDLE:
  - If an unblocked winner exists, go to PEND and register int_o=1 one cycle after the request is seen.
- FSM PEND:
  - int_o stays 1 until inta.
  - On inta: recompute the winner.
  - If a winner exists: latch it as lvl, set isr[lvl] next cycle, pulse irr_clr[lvl] for one cycle.
  - If no winner: lvl=SPUR_LVL, no ISR set, no irr_clr.
  - Clear int_o and go to ACK2.
- FSM ACK2:
  - On inta: vec={VEC_BASE,lvl}, pulse vec_valid for one cycle.
  - If aeoi and the cycle was not spurious: clear isr[lvl] in the same update; if also ar=1, pri_base=lvl.
  - Return to IDLE.
  - Extra inta strobes in IDLE are ignored.
- EOI (any state):
  - Non-specific: clears the highest-rank set isr bit.
  - Specific: clears isr[eoi_lvl].
  - With rot_eoi=1, pri_base = cleared level. If there is nothing to clear, no rotation.
- Simultaneous ISR set and clear in one cycle:
  - isr_next = (isr & ~clr) | set; set wins on the same bit.
  - Rotation from aeoi takes precedence over rotation from eoi.
- Latency: eligible irr to int_o = 1 cycle; inta 1 to isr/irr_clr = 1 cycle; inta 2 to vec_valid = 1 cycle.

Test Plan:
- Single request: reset, imr=0, irr=8'h08 -> int_o=1 next cycle. inta -> isr=8'h08, irr_clr=8'h08 pulse. inta -> vec_valid with vec=8'h0B.
- Nesting: isr=8'h08, irr=8'h21 -> IR0 raises int_o. Then isr=8'h01 only, irr=8'h20 with isr=8'h08 -> int_o stays 0.
- Spurious: int_o=1 from irr=8'h10, then imr=8'h10 before inta -> pulse 2 gives vec=8'h0F, isr unchanged, no irr_clr.
- Non-specific EOI with rotate: isr=8'h0A, eoi=1, eoi_spec=0, rot_eoi=1 -> isr=8'h08, pri_base=1; then IR2 outranks IR0.
- AEOI with ar=1: irr=8'h04 handshake -> isr returns to 0 on pulse 2, pri_base=2.
- Reset mid-cycle: assert rst_n=0 in ACK2 -> all outputs reset immediately; after release, the pending irr restarts from IDLE.
